// File: rtl/lsr_pkg.sv
// Shared types and defaults for the LSR sequencer.
//   DEF_DATA_W / DEF_RES_W : default sample and result widths
//   lsr_state_t            : sequencer FSM states
//   idx_w()                : width of a sample index for a given buffer depth
package lsr_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_RES_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_STREAM,
        ST_WAIT_RES,
        ST_DONE
    } lsr_state_t;

    // Index width for an n-entry buffer; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        if (n < 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/lsr_sample_buf.sv
// Sample register file for the LSR sequencer.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : asynchronous read address
//   rdata  : read data (combinational from raddr)
module lsr_sample_buf #(
    parameter int unsigned DEPTH = 7,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents survive reset so a rerun reuses the same data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lsr_seq_ctrl.sv
// Sequencer for the LSR datapath: buffers DATA_SIZE signed samples, then on
// start clears the datapath, streams (index, scaled sample) beats with
// valid/ready, captures the result and pulses done.
//   clk, rst               : clock, synchronous active-low reset
//   ld_valid/ld_ready/ld_data : sample load handshake
//   flush                  : empty the buffer (idle only)
//   start, shift           : run request and arithmetic right-shift amount
//   busy, done, start_err  : run status, completion pulse, rejected-start pulse
//   result                 : last captured datapath result
//   dp_clr                 : one-cycle accumulator clear
//   dp_valid/dp_ready      : beat handshake carrying dp_x, dp_y, dp_last
//   dp_res_valid, dp_res   : datapath result strobe and value
module lsr_seq_ctrl
    import lsr_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 7,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned RES_W     = DEF_RES_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush,
    input  logic              start,
    input  logic [15:0]       shift,
    output logic              busy,
    output logic              done,
    output logic              start_err,
    output logic [RES_W-1:0]  result,
    output logic              dp_clr,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [DATA_W-1:0] dp_x,
    output logic [DATA_W-1:0] dp_y,
    output logic              dp_last,
    input  logic              dp_res_valid,
    input  logic [RES_W-1:0]  dp_res
);

    localparam int unsigned IDX_W  = idx_w(DATA_SIZE);
    localparam int unsigned CNT_W  = $clog2(DATA_SIZE + 1);
    localparam int unsigned SH_W   = $clog2(DATA_W);
    localparam int unsigned SH_MAX = DATA_W - 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_SIZE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

    lsr_state_t state_q, state_d;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [SH_W-1:0]   shamt_q, shamt_d;
    logic [RES_W-1:0]  result_d;
    logic              start_err_d;
    logic              buf_we;

    logic              ld_ready_d, busy_d, done_d, dp_clr_d, dp_valid_d, dp_last_d;
    logic [DATA_W-1:0] dp_x_d, dp_y_d;

    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] y_shifted;

    // Read port follows the next index so the registered beat is ready on entry.
    lsr_sample_buf #(
        .DEPTH (DATA_SIZE),
        .WIDTH (DATA_W),
        .AW    (IDX_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (IDX_W'(count_q)),
        .wdata (ld_data),
        .raddr (index_d),
        .rdata (rd_data)
    );

    // Sign-filling scale of the selected sample.
    assign y_shifted = rd_data >>> shamt_q;

    // Next-state, counters and latched values.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        index_d     = index_q;
        shamt_d     = shamt_q;
        result_d    = result;
        start_err_d = 1'b0;
        buf_we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Flush beats a same-cycle load and a same-cycle start.
                if (flush) begin
                    count_d = '0;
                end else if (ld_valid && (count_q < CNT_FULL)) begin
                    buf_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
                if (start) begin
                    if (!flush && (count_q == CNT_FULL)) begin
                        state_d = ST_CLR;
                        shamt_d = (shift > 16'(SH_MAX)) ? SH_W'(SH_MAX) : SH_W'(shift);
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            ST_CLR: begin
                index_d = '0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (dp_valid && dp_ready) begin
                    if (index_q == IDX_LAST) begin
                        index_d = '0;
                        state_d = ST_WAIT_RES;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            ST_WAIT_RES: begin
                if (dp_res_valid) begin
                    result_d = dp_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state.
    always_comb begin
        ld_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        dp_clr_d   = 1'b0;
        dp_valid_d = 1'b0;
        dp_last_d  = 1'b0;
        dp_x_d     = '0;
        dp_y_d     = '0;

        ld_ready_d = (state_d == ST_IDLE) && (count_d < CNT_FULL);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        dp_clr_d   = (state_d == ST_CLR);
        if (state_d == ST_STREAM) begin
            dp_valid_d = 1'b1;
            dp_x_d     = DATA_W'(index_d);
            dp_y_d     = y_shifted;
            dp_last_d  = (index_d == IDX_LAST);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            index_q   <= '0;
            shamt_q   <= '0;
            result    <= '0;
            start_err <= 1'b0;
            ld_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            dp_clr    <= 1'b0;
            dp_valid  <= 1'b0;
            dp_last   <= 1'b0;
            dp_x      <= '0;
            dp_y      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            shamt_q   <= shamt_d;
            result    <= result_d;
            start_err <= start_err_d;
            ld_ready  <= ld_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            dp_clr    <= dp_clr_d;
            dp_valid  <= dp_valid_d;
            dp_last   <= dp_last_d;
            dp_x      <= dp_x_d;
            dp_y      <= dp_y_d;
        end
    end

endmodule

// File: tb/tb_lsr_seq_ctrl.sv
// Self-checking bench for lsr_seq_ctrl: directed steps plus randomized runs
// checked against a sample-array reference model.
module tb_lsr_seq_ctrl;

    localparam int unsigned DS = 7;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          flush;
    logic          start;
    logic [15:0]   shift;
    logic          busy;
    logic          done;
    logic          start_err;
    logic [RW-1:0] result;
    logic          dp_clr;
    logic          dp_valid;
    logic          dp_ready;
    logic [DW-1:0] dp_x;
    logic [DW-1:0] dp_y;
    logic          dp_last;
    logic          dp_res_valid;
    logic [RW-1:0] dp_res;

    int total = 0;
    int bad   = 0;

    // Reference model: stored samples, fill level, last result.
    int            mbuf [DS];
    int            mcount  = 0;
    logic [RW-1:0] mresult = '0;

    always #5 clk = ~clk;

    lsr_seq_ctrl #(
        .DATA_SIZE (DS),
        .DATA_W    (DW),
        .RES_W     (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .flush        (flush),
        .start        (start),
        .shift        (shift),
        .busy         (busy),
        .done         (done),
        .start_err    (start_err),
        .result       (result),
        .dp_clr       (dp_clr),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .dp_x         (dp_x),
        .dp_y         (dp_y),
        .dp_last      (dp_last),
        .dp_res_valid (dp_res_valid),
        .dp_res       (dp_res)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scaled sample as floor(s / 2^k), k = min(shift, 15).
    function automatic logic [DW-1:0] exp_y(input int s, input int sh);
        int k;
        int p;
        int q;
        k = (sh > 15) ? 15 : sh;
        p = 1 << k;
        if (s >= 0) q = s / p;
        else        q = -(((-s) + p - 1) / p);
        return DW'(q);
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drive_noise(input bit with_res);
        ld_valid = 1'($urandom);
        ld_data  = DW'($urandom);
        flush    = 1'($urandom);
        start    = 1'($urandom);
        if (with_res) begin
            dp_res_valid = 1'($urandom);
            dp_res       = RW'($urandom);
        end
    endtask

    task automatic clear_noise();
        ld_valid     = 1'b0;
        flush        = 1'b0;
        start        = 1'b0;
        dp_res_valid = 1'b0;
        dp_res       = '0;
    endtask

    // One idle-state cycle; caller never requests an accepted start here.
    task automatic idle_cycle(input bit v, input int d, input bit fl, input bit st);
        bit exp_err;
        chk("ld_ready", ld_ready, 64'(mcount < DS));
        exp_err  = st && (fl || (mcount < DS));
        ld_valid = v;
        ld_data  = DW'(d);
        flush    = fl;
        start    = st;
        step();
        ld_valid = 1'b0;
        flush    = 1'b0;
        start    = 1'b0;
        if (fl) begin
            mcount = 0;
        end else if (v && (mcount < DS)) begin
            mbuf[mcount] = d;
            mcount++;
        end
        chk("start_err", start_err, 64'(exp_err));
        chk("idle_busy", busy, 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) idle_cycle(1'b1, rand_sample(), 1'b0, 1'b0);
    endtask

    // Full run on a full buffer: clear, beats, result capture, done.
    task automatic do_run(input int sh, input bit toggle, input bit noise,
                          input int lat, input logic [RW-1:0] res);
        int            beat;
        int            cyc;
        bit            rdy;
        logic [RW-1:0] prev_res;
        prev_res = mresult;
        chk("pre_ld_ready", ld_ready, 0);
        start = 1'b1;
        shift = 16'(sh);
        step();
        start = 1'b0;
        shift = 16'($urandom);
        chk("busy_rise", busy, 1);
        chk("clr_on", dp_clr, 1);
        chk("clr_valid", dp_valid, 0);
        chk("clr_err", start_err, 0);
        if (noise) drive_noise(1'b1);
        step();
        chk("clr_off", dp_clr, 0);
        beat = 0;
        cyc  = 0;
        while (beat < DS && cyc < 100) begin
            chk("valid", dp_valid, 1);
            chk("x", dp_x, 64'(beat));
            chk("y", dp_y, exp_y(mbuf[beat], sh));
            chk("last", dp_last, 64'(beat == DS - 1));
            chk("ld_ready_run", ld_ready, 0);
            rdy      = toggle ? cyc[0] : 1'b1;
            dp_ready = rdy;
            if (noise) drive_noise(1'b1);
            step();
            if (rdy) beat++;
            cyc++;
        end
        dp_ready = 1'b0;
        clear_noise();
        chk("beat_count", beat, DS);
        chk("res_ignored", result, prev_res);
        for (int i = 0; i < lat; i++) begin
            chk("wait_valid", dp_valid, 0);
            chk("wait_done", done, 0);
            chk("wait_busy", busy, 1);
            if (noise) drive_noise(1'b0);
            step();
        end
        dp_res_valid = 1'b1;
        dp_res       = res;
        step();
        clear_noise();
        chk("done_on", done, 1);
        chk("result", result, res);
        chk("busy_done", busy, 1);
        if (noise) drive_noise(1'b0);
        step();
        clear_noise();
        mresult = res;
        chk("done_off", done, 0);
        chk("busy_fall", busy, 0);
        chk("result_hold", result, res);
        chk("ld_ready_after", ld_ready, 0);
    endtask

    initial begin
        rst          = 1'b0;
        ld_valid     = 1'b0;
        ld_data      = '0;
        flush        = 1'b0;
        start        = 1'b0;
        shift        = '0;
        dp_ready     = 1'b0;
        dp_res_valid = 1'b0;
        dp_res       = '0;

        // Reset held for two cycles.
        step();
        step();
        rst = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", start_err, 0);
        chk("rst_result", result, 0);
        chk("rst_clr", dp_clr, 0);
        chk("rst_valid", dp_valid, 0);
        chk("rst_last", dp_last, 0);
        chk("rst_x", dp_x, 0);
        chk("rst_y", dp_y, 0);
        chk("rst_ld_ready", ld_ready, 1);

        // 10..70, shift 0, dp_ready high; extra load on a full buffer is dropped.
        for (int i = 0; i < DS; i++) idle_cycle(1'b1, (i + 1) * 10, 1'b0, 1'b0);
        idle_cycle(1'b1, 99, 1'b0, 1'b0);
        do_run(0, 1'b0, 1'b0, 2, 32'h0000_000A);

        // Same data with dp_ready toggling.
        do_run(0, 1'b1, 1'b0, 1, 32'h0000_1234);

        // Negative/positive samples with shift 2.
        idle_cycle(1'b0, 0, 1'b1, 1'b0);
        idle_cycle(1'b1, -8, 1'b0, 1'b0);
        idle_cycle(1'b1, 5, 1'b0, 1'b0);
        fill_random(DS - 2);
        do_run(2, 1'b0, 1'b0, 0, RW'($urandom));

        // Shift beyond 15 clamps; -1 stays -1.
        idle_cycle(1'b0, 0, 1'b1, 1'b0);
        idle_cycle(1'b1, -1, 1'b0, 1'b0);
        idle_cycle(1'b1, -32768, 1'b0, 1'b0);
        fill_random(DS - 2);
        do_run(20, 1'b1, 1'b0, 3, RW'($urandom));

        // Flush and start together on a full buffer: flush wins, error pulses.
        idle_cycle(1'b0, 0, 1'b1, 1'b1);

        // Start on a partial buffer is rejected; then fill and run with noise.
        fill_random(3);
        idle_cycle(1'b0, 0, 1'b0, 1'b1);
        fill_random(DS - 3);
        do_run(int'($urandom_range(0, 20)), 1'b0, 1'b1, 2, RW'($urandom));
        do_run(int'($urandom_range(0, 20)), 1'b1, 1'b0, 1, RW'($urandom));

        // Reset after the third beat.
        chk("pre_rst_ld_ready", ld_ready, 0);
        start = 1'b1;
        shift = 16'd1;
        step();
        start = 1'b0;
        step();
        dp_ready = 1'b1;
        step();
        step();
        step();
        chk("rst_mid_valid_pre", dp_valid, 1);
        chk("rst_mid_x_pre", dp_x, 3);
        rst = 1'b0;
        step();
        rst      = 1'b1;
        dp_ready = 1'b0;
        mcount   = 0;
        mresult  = '0;
        chk("rst_mid_valid", dp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_last", dp_last, 0);
        chk("rst_mid_clr", dp_clr, 0);
        chk("rst_mid_result", result, 0);
        fill_random(DS);
        idle_cycle(1'b1, 77, 1'b0, 1'b0);
        do_run(3, 1'b0, 1'b0, 1, RW'($urandom));

        // Flush with a same-cycle load on a partial buffer drops the load.
        idle_cycle(1'b0, 0, 1'b1, 1'b0);
        fill_random(3);
        idle_cycle(1'b1, 1234, 1'b1, 1'b0);
        fill_random(DS);
        idle_cycle(1'b1, 4321, 1'b0, 1'b0);
        do_run(0, 1'b0, 1'b0, 0, RW'($urandom));

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            idle_cycle(1'b0, 0, 1'b1, 1'b0);
            fill_random(DS);
            do_run(int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), RW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
